// File: rtl/min_prio_arbiter_if.sv
// ---------------------------------------------------------------------------
// min_prio_arbiter_if
// Request/grant bundle between four requesters and min_prio_arbiter.
//   req[3:0]          request per requester (bit i = requester i)
//   prio0..prio3      priority of requester i, WIDTH bits, 0 = most urgent
//   done              current owner releases the grant
//   gnt[3:0]          one-hot registered grant
//   gnt_idx[1:0]      index of granted requester (valid when gnt_valid=1)
//   gnt_valid         high while a grant is held
//   timeout           one-cycle pulse in the last cycle of a forced release
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface min_prio_arbiter_if #(
  parameter int WIDTH = 3
);
  logic [3:0]       req;
  logic [WIDTH-1:0] prio0;
  logic [WIDTH-1:0] prio1;
  logic [WIDTH-1:0] prio2;
  logic [WIDTH-1:0] prio3;
  logic             done;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, prio0, prio1, prio2, prio3, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, prio0, prio1, prio2, prio3, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/min_prio_arbiter.sv
// ---------------------------------------------------------------------------
// min_prio_arbiter
// Four-requester arbiter: the requester with the lowest effective priority
// value wins (ties to the lowest index). The grant is registered, held until
// the owner signals done, drops its request, or HOLD_MAX cycles elapse, then
// the block spends one IDLE cycle re-arbitrating.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  min_prio_arbiter_if.slave (req, prio0..3, done -> gnt, gnt_idx,
//        gnt_valid, timeout)
// Parameters: WIDTH (priority width), HOLD_MAX (1..255 grant cycles),
//   AGE_PERIOD (waiting cycles per aging step).
// Optional build macro MIN_PRIO_ARBITER_AGING_EN: starved requesters earn a
//   bonus that is subtracted (saturating at 0) from their priority.
// ---------------------------------------------------------------------------
module min_prio_arbiter #(
  parameter int WIDTH      = 3,
  parameter int HOLD_MAX   = 15,
  parameter int AGE_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst,
  min_prio_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] hold_inc_s;
  logic       release_s;

  logic [WIDTH-1:0] prio_s [4];
  logic [WIDTH-1:0] eff_prio_s [4];
  logic [WIDTH-1:0] best_s;
  logic             found_s;
  logic             take_s;
  logic [1:0]       win_idx_s;

  assign prio_s[0] = bus.prio0;
  assign prio_s[1] = bus.prio1;
  assign prio_s[2] = bus.prio2;
  assign prio_s[3] = bus.prio3;

`ifdef MIN_PRIO_ARBITER_AGING_EN
  localparam logic [7:0]       AGE_LAST  = 8'(AGE_PERIOD - 1);
  localparam logic [WIDTH-1:0] BONUS_MAX = {WIDTH{1'b1}};

  logic [7:0]       wait_q [4];
  logic [7:0]       wait_d [4];
  logic [WIDTH-1:0] bonus_q [4];
  logic [WIDTH-1:0] bonus_d [4];

  // Aging counters: a waiting requester earns one bonus step per AGE_PERIOD
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wait_d[i]  = wait_q[i];
      bonus_d[i] = bonus_q[i];
      if (!bus.req[i] || gnt_q[i]) begin
        wait_d[i]  = 8'd0;
        bonus_d[i] = {WIDTH{1'b0}};
      end else if (wait_q[i] == AGE_LAST) begin
        wait_d[i]  = 8'd0;
        bonus_d[i] = (bonus_q[i] == BONUS_MAX) ? BONUS_MAX : bonus_q[i] + WIDTH'(1);
      end else begin
        wait_d[i]  = (wait_q[i] == 8'hFF) ? 8'hFF : wait_q[i] + 8'd1;
        bonus_d[i] = bonus_q[i];
      end
    end
  end

  // Aging counter registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        wait_q[i]  <= 8'd0;
        bonus_q[i] <= {WIDTH{1'b0}};
      end else begin
        wait_q[i]  <= wait_d[i];
        bonus_q[i] <= bonus_d[i];
      end
    end
  end

  // Effective priority: priority minus bonus, floored at zero
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eff_prio_s[i] = (prio_s[i] > bonus_q[i]) ? (prio_s[i] - bonus_q[i]) : {WIDTH{1'b0}};
    end
  end
`else
  // Effective priority is the raw priority when aging is not built
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eff_prio_s[i] = prio_s[i];
    end
  end
`endif

  // Minimum search; strict less-than keeps the lowest index on ties
  always_comb begin
    best_s    = {WIDTH{1'b1}};
    found_s   = 1'b0;
    take_s    = 1'b0;
    win_idx_s = 2'd0;
    for (int i = 0; i < 4; i++) begin
      take_s    = bus.req[i] && (!found_s || (eff_prio_s[i] < best_s));
      best_s    = take_s ? eff_prio_s[i] : best_s;
      win_idx_s = take_s ? 2'(i) : win_idx_s;
      found_s   = found_s | take_s;
    end
  end

  assign hold_inc_s = hold_cnt_q + 8'd1;
  assign release_s  = bus.done | ~bus.req[gnt_idx_q] | (hold_cnt_q == HOLD_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_d     = GRANT;
          gnt_d       = 4'b0001 << win_idx_s;
          gnt_idx_d   = win_idx_s;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd0;
          // HOLD_MAX=1: the first grant cycle is already the forced-release one
          timeout_d   = (HOLD_LAST == 8'd0);
        end else begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_idx_d   = 2'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_idx_d   = 2'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end else begin
          state_d    = GRANT;
          hold_cnt_d = hold_inc_s;
          // Raise timeout for the cycle in which the hold limit forces release
          timeout_d  = (hold_inc_s == HOLD_LAST);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        gnt_idx_d   = 2'd0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = 8'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule
